// File: rtl/tc08_motion_ctl.sv
// TC08 tape motion sequencer: drives unit select, go and direction to TU55 transports,
// enforcing stop-before-turnaround dwell and a timing-track watchdog while at speed.
module tc08_motion_ctl #(
  parameter int NUM_UNITS   = 8,
  parameter int UP_CYCLES   = 15000000,
  parameter int STOP_CYCLES = 10000000,
  parameter int TMK_TIMEOUT = 4096,
  parameter int CNT_W       = 24
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_unit,
  input  logic [1:0]           cmd_op,
  output logic [NUM_UNITS-1:0] unit_sel_l,
  output logic                 t_go_l,
  output logic                 t_fwd_l,
  input  logic                 t_trk_pos,
  output logic                 up_to_speed,
  output logic                 busy,
  output logic                 timing_err
);

  typedef enum logic [1:0] {IDLE, ACCEL, RUN, DECEL} state_t;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_FWD   = 2'b01;
  localparam logic [1:0] OP_REV   = 2'b10;
  localparam logic [1:0] OP_DESEL = 2'b11;

  localparam logic [CNT_W-1:0] UP_LOAD   = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMK_LIMIT = CNT_W'(TMK_TIMEOUT);

  // Command parked while the transport decelerates; dir=1 means forward.
  typedef struct packed {
    logic       valid;
    logic [2:0] unit;
    logic       dir;
    logic       desel;
  } pend_t;

  state_t               state, state_nxt;
  pend_t                pend, pend_nxt;
  logic [2:0]           cur_unit, cur_unit_nxt;
  logic                 cur_dir, cur_dir_nxt;
  logic [NUM_UNITS-1:0] sel_l, sel_l_nxt;
  logic                 go_l, go_l_nxt;
  logic                 fwd_l, fwd_l_nxt;
  logic [CNT_W-1:0]     dwell, dwell_nxt;
  logic [CNT_W-1:0]     wdog, wdog_nxt;
  logic                 err, err_nxt;
  logic                 trk_s1, trk_s2, trk_s3;

  logic accept, in_range, cmd_move, cmd_desel, cmd_dir, same_cmd, trk_edge;

  function automatic logic [NUM_UNITS-1:0] sel_of(input logic [2:0] u);
    return ~(NUM_UNITS'(1) << u);
  endfunction

  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = 32'(cmd_unit) < NUM_UNITS;
  assign cmd_move  = in_range && (cmd_op == OP_FWD || cmd_op == OP_REV);
  assign cmd_desel = !in_range || cmd_op == OP_DESEL;
  assign cmd_dir   = (cmd_op == OP_FWD);
  assign same_cmd  = cmd_move && cmd_unit == cur_unit && cmd_dir == cur_dir;
  assign trk_edge  = trk_s2 ^ trk_s3;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      pend     <= '0;
      cur_unit <= '0;
      cur_dir  <= 1'b0;
      sel_l    <= '1;
      go_l     <= 1'b1;
      fwd_l    <= 1'b1;
      dwell    <= '0;
      wdog     <= '0;
      err      <= 1'b0;
      trk_s1   <= 1'b0;
      trk_s2   <= 1'b0;
      trk_s3   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      cur_unit <= cur_unit_nxt;
      cur_dir  <= cur_dir_nxt;
      sel_l    <= sel_l_nxt;
      go_l     <= go_l_nxt;
      fwd_l    <= fwd_l_nxt;
      dwell    <= dwell_nxt;
      wdog     <= wdog_nxt;
      err      <= err_nxt;
      trk_s1   <= t_trk_pos;
      trk_s2   <= trk_s1;
      trk_s3   <= trk_s2;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    cur_unit_nxt = cur_unit;
    cur_dir_nxt  = cur_dir;
    sel_l_nxt    = sel_l;
    go_l_nxt     = go_l;
    fwd_l_nxt    = fwd_l;
    dwell_nxt    = (dwell != '0) ? dwell - 1'b1 : '0;
    wdog_nxt     = '0;
    err_nxt      = accept ? 1'b0 : err;

    unique case (state)
      IDLE: begin
        if (accept && cmd_move) begin
          cur_unit_nxt = cmd_unit;
          cur_dir_nxt  = cmd_dir;
          sel_l_nxt    = sel_of(cmd_unit);
          go_l_nxt     = 1'b0;
          fwd_l_nxt    = !cmd_dir;
          dwell_nxt    = UP_LOAD;
          state_nxt    = ACCEL;
        end else if (accept && cmd_desel) begin
          sel_l_nxt = '1;
        end
      end

      ACCEL, RUN: begin
        if (state == RUN) wdog_nxt = trk_edge ? '0 : wdog + 1'b1;
        if (state == RUN && wdog_nxt >= TMK_LIMIT) begin
          // Lost tape motion: the error set overrides a coincident command's clear.
          err_nxt   = 1'b1;
          wdog_nxt  = '0;
          pend_nxt  = '0;
          go_l_nxt  = 1'b1;
          dwell_nxt = STOP_LOAD;
          state_nxt = DECEL;
        end else if (accept && !same_cmd) begin
          pend_nxt.valid = cmd_move;
          pend_nxt.unit  = cmd_unit;
          pend_nxt.dir   = cmd_dir;
          pend_nxt.desel = cmd_desel;
          wdog_nxt       = '0;
          go_l_nxt       = 1'b1;
          dwell_nxt      = STOP_LOAD;
          state_nxt      = DECEL;
        end else if (state == ACCEL && dwell == '0) begin
          wdog_nxt  = '0;
          state_nxt = RUN;
        end
      end

      DECEL: begin
        if (dwell == '0) begin
          pend_nxt = '0;
          if (pend.valid) begin
            cur_unit_nxt = pend.unit;
            cur_dir_nxt  = pend.dir;
            sel_l_nxt    = sel_of(pend.unit);
            fwd_l_nxt    = !pend.dir;
            go_l_nxt     = 1'b0;
            dwell_nxt    = UP_LOAD;
            state_nxt    = ACCEL;
          end else begin
            if (pend.desel) sel_l_nxt = '1;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state != DECEL);
    up_to_speed = (state == RUN);
    busy        = (state != IDLE);
    unit_sel_l  = sel_l;
    t_go_l      = go_l;
    t_fwd_l     = fwd_l;
    timing_err  = err;
  end

endmodule
